// File: rtl/seq_det_pkg.sv
// Shared encodings for the serial pattern detector: FSM states and detection modes.
package seq_det_pkg;

    typedef enum logic {
        ST_FILL  = 1'b0,
        ST_ARMED = 1'b1
    } state_e;

    localparam logic MODE_NONOVL = 1'b0;
    localparam logic MODE_OVL    = 1'b1;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a sticky flag that is set when the count reaches all-ones.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         sat
);

    logic [W-1:0] count_q, count_d;
    logic         sat_q, sat_d;

    always_comb begin
        count_d = count_q;
        sat_d   = sat_q;
        if (clr) begin
            count_d = '0;
            sat_d   = 1'b0;
        end else if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + 1'b1;
            if (count_d == {W{1'b1}}) begin
                sat_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            sat_q   <= sat_d;
        end
    end

    assign count = count_q;
    assign sat   = sat_q;

endmodule

// File: rtl/seq_pattern_detector.sv
// Serial pattern detector: shift history, fill/armed FSM and live pattern compare,
// with a registered match pulse and a saturating match counter.
module seq_pattern_detector
    import seq_det_pkg::*;
#(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             x,
    input  logic [PAT_W-1:0] pattern,
    input  logic             overlap,
    input  logic             clr,
    output logic             match,
    output logic [CNT_W-1:0] match_count,
    output logic             cnt_sat
);

    localparam int FW = $clog2(PAT_W);
    localparam logic [FW-1:0] FILL_LAST = FW'(PAT_W - 1);

    logic [PAT_W-1:0] hist_q, hist_d;
    logic [FW-1:0]    fill_q, fill_d;
    state_e           state_q, state_d;
    logic             match_q, match_d;
    logic [PAT_W-1:0] window_next;
    logic             hit;

    always_comb begin
        hist_d      = hist_q;
        fill_d      = fill_q;
        state_d     = state_q;
        hit         = 1'b0;
        window_next = (hist_q << 1) | PAT_W'(x);
        if (clr) begin
            hist_d  = '0;
            fill_d  = '0;
            state_d = ST_FILL;
        end else if (en) begin
            hist_d = window_next;
            hit    = (window_next == pattern) &&
                     ((state_q == ST_ARMED) || (fill_q == FILL_LAST));
            // A non-overlapping match restarts the window, even when it completes during FILL.
            if (hit && (overlap == MODE_NONOVL)) begin
                state_d = ST_FILL;
                fill_d  = '0;
            end else if (state_q == ST_FILL) begin
                if (fill_q == FILL_LAST) begin
                    state_d = ST_ARMED;
                    fill_d  = '0;
                end else begin
                    fill_d = fill_q + 1'b1;
                end
            end
        end
        match_d = hit;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_q  <= '0;
            fill_q  <= '0;
            state_q <= ST_FILL;
            match_q <= 1'b0;
        end else begin
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            state_q <= state_d;
            match_q <= match_d;
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .inc  (hit),
        .count(match_count),
        .sat  (cnt_sat)
    );

    assign match = match_q;

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Scoreboard bench for seq_pattern_detector: a bit-queue reference model predicts
// each cycle's outputs for an 8-bit and a 2-bit counter instance sharing one stream.
module tb_seq_pattern_detector;
    import seq_det_pkg::*;

    localparam int PAT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic             x;
    logic [PAT_W-1:0] pattern;
    logic             overlap;
    logic             clr;
    logic             match8, sat8, match2, sat2;
    logic [7:0]       cnt8;
    logic [1:0]       cnt2;

    always #5 clk = ~clk;

    seq_pattern_detector #(.PAT_W(PAT_W), .CNT_W(8)) dut (
        .clk(clk), .rst(rst_n), .en(en), .x(x), .pattern(pattern),
        .overlap(overlap), .clr(clr), .match(match8),
        .match_count(cnt8), .cnt_sat(sat8)
    );

    seq_pattern_detector #(.PAT_W(PAT_W), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst_n), .en(en), .x(x), .pattern(pattern),
        .overlap(overlap), .clr(clr), .match(match2),
        .match_count(cnt2), .cnt_sat(sat2)
    );

    typedef struct {
        logic m;
        int   c8;
        logic s8;
        int   c2;
        logic s2;
    } exp_t;

    exp_t sb[$];
    bit   bits_q[$];
    int   m_c8 = 0;
    bit   m_s8 = 0;
    int   m_c2 = 0;
    bit   m_s2 = 0;
    int   checks = 0;
    int   errors = 0;

    // Reference: valid bits since the last restart; a match needs PAT_W of them.
    task automatic drive(input logic e, input logic xi, input logic c, output logic m_obs);
        exp_t ex;
        logic [PAT_W-1:0] w;
        logic hitm;
        en   = e;
        x    = xi;
        clr  = c;
        hitm = 1'b0;
        if (!rst_n || c) begin
            bits_q.delete();
            m_c8 = 0; m_s8 = 0; m_c2 = 0; m_s2 = 0;
        end else if (e) begin
            bits_q.push_back(xi);
            if (bits_q.size() > PAT_W) void'(bits_q.pop_front());
            if (bits_q.size() == PAT_W) begin
                for (int i = 0; i < PAT_W; i++) w[i] = bits_q[PAT_W-1-i];
                hitm = (w == pattern);
            end
            if (hitm) begin
                if (m_c8 < 255) m_c8 = m_c8 + 1;
                if (m_c8 == 255) m_s8 = 1;
                if (m_c2 < 3) m_c2 = m_c2 + 1;
                if (m_c2 == 3) m_s2 = 1;
                if (overlap == MODE_NONOVL) bits_q.delete();
            end
        end
        ex.m = hitm; ex.c8 = m_c8; ex.s8 = m_s8; ex.c2 = m_c2; ex.s2 = m_s2;
        sb.push_back(ex);
        @(negedge clk);
        m_obs = match8;
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks += 5;
            if (match8 !== e.m) begin errors++; $display("FAIL sb_match8 got %b exp %b t=%0t", match8, e.m, $time); end
            if (cnt8 !== 8'(e.c8)) begin errors++; $display("FAIL sb_cnt8 got %0d exp %0d t=%0t", cnt8, e.c8, $time); end
            if (sat8 !== e.s8) begin errors++; $display("FAIL sb_sat8 got %b exp %b t=%0t", sat8, e.s8, $time); end
            if (cnt2 !== 2'(e.c2) || match2 !== e.m) begin errors++; $display("FAIL sb_cnt2 got %0d/%b exp %0d/%b t=%0t", cnt2, match2, e.c2, e.m, $time); end
            if (sat2 !== e.s2) begin errors++; $display("FAIL sb_sat2 got %b exp %b t=%0t", sat2, e.s2, $time); end
            $display("txn t=%0t en=%b x=%b clr=%b match=%b cnt8=%0d cnt2=%0d sat2=%b", $time, en, x, clr, match8, cnt8, cnt2, sat2);
        end
    end

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; x = 1'b0; clr = 1'b0;
        pattern = 4'b1011; overlap = MODE_OVL;
        #2;
        checks++;
        if ({match8, cnt8, sat8, match2, cnt2, sat2} !== 13'd0) begin
            errors++; $display("FAIL reset_outputs got %b exp 0", {match8, cnt8, sat8, match2, cnt2, sat2});
        end
        en = 1'b1; x = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({match8, cnt8, sat8} !== 10'd0) begin
            errors++; $display("FAIL reset_held got %b exp 0", {match8, cnt8, sat8});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_overlap();
        logic s [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [6:0] mask;
        logic m;
        pattern = 4'b1011; overlap = MODE_OVL;
        drive(1'b1, 1'b1, 1'b1, m);
        for (int i = 0; i < 7; i++) begin drive(1'b1, s[i], 1'b0, m); mask[i] = m; end
        checks += 3;
        if (mask !== 7'b1001000) begin errors++; $display("FAIL ovl_pulses got %b exp 1001000", mask); end
        if (cnt8 !== 8'd2) begin errors++; $display("FAIL ovl_count got %0d exp 2", cnt8); end
        if (sat8 !== 1'b0) begin errors++; $display("FAIL ovl_sat got %b exp 0", sat8); end
    endtask

    task automatic test_nonoverlap();
        logic s [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [6:0] mask;
        logic m;
        pattern = 4'b1011; overlap = MODE_NONOVL;
        drive(1'b1, 1'b1, 1'b1, m);
        for (int i = 0; i < 7; i++) begin drive(1'b1, s[i], 1'b0, m); mask[i] = m; end
        checks += 2;
        if (mask !== 7'b0001000) begin errors++; $display("FAIL novl_pulses got %b exp 0001000", mask); end
        if (cnt8 !== 8'd1) begin errors++; $display("FAIL novl_count got %0d exp 1", cnt8); end
    endtask

    task automatic test_back_to_back();
        logic [5:0] mask;
        logic m;
        pattern = 4'b1111; overlap = MODE_OVL;
        drive(1'b1, 1'b1, 1'b1, m);
        for (int i = 0; i < 6; i++) begin drive(1'b1, 1'b1, 1'b0, m); mask[i] = m; end
        checks += 2;
        if (mask !== 6'b111000) begin errors++; $display("FAIL b2b_pulses got %b exp 111000", mask); end
        if (cnt8 !== 8'd3) begin errors++; $display("FAIL b2b_count got %0d exp 3", cnt8); end
    endtask

    task automatic test_en_gaps();
        logic s [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        int step = 0, pulses = 0, pulse_idx = -1;
        logic m;
        pattern = 4'b1011; overlap = MODE_OVL;
        drive(1'b1, 1'b1, 1'b1, m);
        for (int q = 0; q < 4; q++) begin
            drive(1'b1, s[q], 1'b0, m);
            if (m) begin pulses++; pulse_idx = step; end
            step++;
            for (int k = 0; k < 3; k++) begin
                drive(1'b0, 1'($urandom_range(1)), 1'b0, m);
                if (m) begin pulses++; pulse_idx = step; end
                step++;
            end
        end
        checks += 2;
        if (pulses !== 1) begin errors++; $display("FAIL gap_pulse_count got %0d exp 1", pulses); end
        if (pulse_idx !== 12) begin errors++; $display("FAIL gap_pulse_step got %0d exp 12", pulse_idx); end
    endtask

    task automatic test_midstream_reset();
        logic s [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic [3:0] mask;
        logic m;
        pattern = 4'b1011; overlap = MODE_OVL;
        drive(1'b1, 1'b1, 1'b1, m);
        drive(1'b1, 1'b1, 1'b0, m);
        drive(1'b1, 1'b0, 1'b0, m);
        drive(1'b1, 1'b1, 1'b0, m);
        rst_n = 1'b0;
        drive(1'b1, 1'b1, 1'b0, m);
        drive(1'b1, 1'b1, 1'b0, m);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin drive(1'b1, s[i], 1'b0, m); mask[i] = m; end
        checks += 2;
        if (mask !== 4'b1000) begin errors++; $display("FAIL rst_fresh_pulses got %b exp 1000", mask); end
        if (cnt8 !== 8'd1) begin errors++; $display("FAIL rst_fresh_count got %0d exp 1", cnt8); end
    endtask

    task automatic test_saturation();
        int   exp_c [7] = '{0, 0, 0, 1, 2, 3, 3};
        logic exp_s [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic m;
        pattern = 4'b1111; overlap = MODE_OVL;
        drive(1'b1, 1'b1, 1'b1, m);
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 1'b1, 1'b0, m);
            checks += 2;
            if (cnt2 !== 2'(exp_c[i])) begin errors++; $display("FAIL sat_count[%0d] got %0d exp %0d", i, cnt2, exp_c[i]); end
            if (sat2 !== exp_s[i]) begin errors++; $display("FAIL sat_flag[%0d] got %b exp %b", i, sat2, exp_s[i]); end
        end
        drive(1'b1, 1'b1, 1'b1, m);
        checks += 4;
        if (cnt2 !== 2'd0) begin errors++; $display("FAIL clr_count got %0d exp 0", cnt2); end
        if (sat2 !== 1'b0) begin errors++; $display("FAIL clr_sat got %b exp 0", sat2); end
        if (m !== 1'b0 || match2 !== 1'b0) begin errors++; $display("FAIL clr_match got %b/%b exp 0", m, match2); end
        if (dut2.state_q !== ST_FILL) begin errors++; $display("FAIL clr_state got %b exp %b", dut2.state_q, ST_FILL); end
    endtask

    initial begin
        test_reset();
        test_overlap();
        test_nonoverlap();
        test_back_to_back();
        test_en_gaps();
        test_midstream_reset();
        test_saturation();
        en = 1'b0; clr = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL sb_drain got %0d exp 0", sb.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running exp finished");
        $fatal(1);
    end

endmodule
